// File: rtl/handshake_pulse_tx_pkg.sv
`default_nettype none
// handshake_pulse_tx_pkg: shared types and limits for the pulse-transfer source.
// Rev 1.0
package handshake_pulse_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_e;

    localparam int C_SYNC_STAGES_MIN = 2;
    localparam int C_SYNC_STAGES_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/handshake_pulse_tx_ack_synchronizer.sv
`default_nettype none
// ack_synchronizer: multi-flop synchroniser for a level crossing into clock.
// Rev 1.0
module ack_synchronizer
    import handshake_pulse_tx_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    // Out-of-range depths are clamped rather than producing a broken chain.
    localparam int C_DEPTH = (STAGES < C_SYNC_STAGES_MIN) ? C_SYNC_STAGES_MIN :
                             (STAGES > C_SYNC_STAGES_MAX) ? C_SYNC_STAGES_MAX : STAGES;

    logic [C_DEPTH-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[C_DEPTH-2:0], async_i};
        end
    end

    assign sync_o = sync_q[C_DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/handshake_pulse_tx.sv
`default_nettype none
// handshake_pulse_tx: queues event pulses and sends them one at a time over a 4-phase req/ack link.
// Rev 1.0
module handshake_pulse_tx
    import handshake_pulse_tx_pkg::*;
#(
    parameter int PENDING_WIDTH = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pulseIn,
    input  logic                     ackIn,
    output logic                     reqOut,
    output logic                     busyOut,
    output logic                     doneOut,
    output logic [PENDING_WIDTH-1:0] pendingOut,
    output logic                     overflowOut
);

    localparam logic [PENDING_WIDTH-1:0] C_COUNT_MAX = '1;
    localparam logic [PENDING_WIDTH-1:0] C_COUNT_ONE = PENDING_WIDTH'(1);

    hs_state_e                state_q, state_d;
    logic [PENDING_WIDTH-1:0] count_q, count_d;
    logic                     req_q, req_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;

    logic w_ack_sync;
    logic w_launch;

    ack_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (ackIn),
        .sync_o  (w_ack_sync)
    );

    assign w_launch = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        // A pulse coinciding with a launch leaves the count unchanged, so it can never overflow.
        if (pulseIn && !w_launch) begin
            if (count_q == C_COUNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + C_COUNT_ONE;
            end
        end else if (!pulseIn && w_launch) begin
            count_d = count_q - C_COUNT_ONE;
        end

        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_launch) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                if (w_ack_sync) begin
                    state_d = RELEASE;
                    req_d   = 1'b0;
                end
            end
            RELEASE: begin
                if (!w_ack_sync) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign reqOut      = req_q;
    assign busyOut     = busy_q;
    assign doneOut     = done_q;
    assign pendingOut  = count_q;
    assign overflowOut = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_pulse_tx.sv
`default_nettype none
// tb_handshake_pulse_tx: randomized self-checking bench with a behavioural reference model.
// Rev 1.0
module tb_handshake_pulse_tx;

    localparam int P    = 10;
    localparam int A_PW = 4;
    localparam int A_SS = 2;
    localparam int B_PW = 2;
    localparam int B_SS = 3;
    localparam int A_MAX = (1 << A_PW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #(P/2) clk = ~clk;

    // Instance A: default sizing, ack driven synchronously, checked cycle by cycle
    logic            a_pulse = 1'b0, a_ack = 1'b0;
    logic            a_req, a_busy, a_done, a_ovf;
    logic [A_PW-1:0] a_pend;
    // Instance B: small counter, deeper synchroniser, ack driven at random phase
    logic            b_pulse = 1'b0, b_ack = 1'b0;
    logic            b_req, b_busy, b_done, b_ovf;
    logic [B_PW-1:0] b_pend;

    handshake_pulse_tx #(.PENDING_WIDTH(A_PW), .SYNC_STAGES(A_SS)) u_dut_a (
        .clock(clk), .reset(rst), .pulseIn(a_pulse), .ackIn(a_ack),
        .reqOut(a_req), .busyOut(a_busy), .doneOut(a_done),
        .pendingOut(a_pend), .overflowOut(a_ovf)
    );

    handshake_pulse_tx #(.PENDING_WIDTH(B_PW), .SYNC_STAGES(B_SS)) u_dut_b (
        .clock(clk), .reset(rst), .pulseIn(b_pulse), .ackIn(b_ack),
        .reqOut(b_req), .busyOut(b_busy), .doneOut(b_done),
        .pendingOut(b_pend), .overflowOut(b_ovf)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Remote receivers: ack follows req after a latency in cycles
    logic a_ack_en = 1'b0, a_rand = 1'b0;
    int   a_lat_cfg = 3;
    logic b_ack_en = 1'b0, b_async = 1'b0;
    time  b_ack_rise_t = 0;

    initial begin
        int cnt, tgt;
        cnt = 0; tgt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                a_ack = 1'b0; cnt = 0;
            end else if (a_ack_en && (a_req != a_ack)) begin
                if (cnt == 0) tgt = a_rand ? int'($urandom_range(0, 6)) : a_lat_cfg;
                if (cnt >= tgt) begin
                    a_ack = a_req; cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        int cnt, tgt;
        cnt = 0; tgt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                b_ack = 1'b0; cnt = 0;
            end else if (b_ack_en && (b_req != b_ack)) begin
                if (cnt == 0) tgt = b_async ? int'($urandom_range(0, 8)) : 2;
                if (cnt >= tgt) begin
                    if (b_async) #($urandom_range(1, 9));
                    if (!b_ack && b_req) b_ack_rise_t = $time;
                    b_ack = b_req; cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Reference model for A: event count plus an in-flight transfer with an "ack seen" flag.
    // The synchroniser is a pure SYNC_STAGES-cycle delay of ackIn.
    int              m_cnt = 0;
    bit              m_hs = 0, m_acked = 0, m_done = 0, m_ovf = 0;
    logic [A_SS-1:0] m_ackdly = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cnt = 0; m_hs = 0; m_acked = 0; m_done = 0; m_ovf = 0; m_ackdly = '0;
        end else begin
            bit ack_seen, start;
            ack_seen = m_ackdly[A_SS-1];
            start    = !m_hs && (m_cnt > 0);
            m_ovf    = a_pulse && !start && (m_cnt == A_MAX);
            m_cnt    = m_cnt + int'(a_pulse) - int'(start);
            if (m_cnt > A_MAX) m_cnt = A_MAX;
            m_done = 0;
            if (start) begin
                m_hs = 1; m_acked = 0;
            end else if (m_hs && !m_acked && ack_seen) begin
                m_acked = 1;
            end else if (m_hs && m_acked && !ack_seen) begin
                m_hs = 0; m_done = 1;
            end
            m_ackdly = {m_ackdly[A_SS-2:0], a_ack};
        end
    end

    // Per-cycle comparison of A against the model, plus monitors
    logic a_cmp_en = 1'b0;
    int   a_done_cnt = 0;
    int   b_done_cnt = 0;
    int   b_ovf_cnt  = 0;

    initial forever begin
        @(negedge clk);
        if (a_cmp_en) begin
            chk("a_req",      32'(a_req),  32'(m_hs && !m_acked));
            chk("a_pending",  32'(a_pend), 32'(m_cnt));
            chk("a_busy",     32'(a_busy), 32'(m_hs || (m_cnt != 0)));
            chk("a_done",     32'(a_done), 32'(m_done));
            chk("a_overflow", 32'(a_ovf),  32'(m_ovf));
        end
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
        if (b_ovf)  b_ovf_cnt++;
    end

    // reqOut must stay low at least two cycles between consecutive requests
    initial begin
        int  low_run;
        bit  seen, prev;
        low_run = 0; seen = 0; prev = 0;
        forever begin
            @(negedge clk);
            if (a_req) begin
                if (!prev && seen) chk("a_req_gap", 32'(low_run >= 2), 32'd1);
                seen = 1; low_run = 0;
            end else begin
                low_run++;
            end
            prev = a_req;
        end
    end

    // B: a request may only fall once the ack rise has crossed all sync stages
    initial forever begin
        @(negedge b_req);
        if (!rst) chk("b_req_fall_latency", 32'(($time - b_ack_rise_t) >= B_SS * P), 32'd1);
    end

    task automatic a_pulses(input int n);
        repeat (n) begin
            @(negedge clk); a_pulse = 1'b1;
        end
        @(negedge clk); a_pulse = 1'b0;
    endtask

    task automatic a_drain(input string tag, input int budget, output int peak);
        int i;
        i = 0; peak = int'(a_pend);
        while (i < budget && (a_busy || a_req || a_ack)) begin
            @(negedge clk);
            if (int'(a_pend) > peak) peak = int'(a_pend);
            i++;
        end
        chk({tag, "_idle"}, {29'd0, a_busy, a_req, a_ack}, 32'd0);
    endtask

    task automatic b_drain(input string tag, input int budget);
        int i;
        i = 0;
        while (i < budget && (b_busy || b_req || b_ack)) begin
            @(negedge clk); i++;
        end
        chk({tag, "_idle"}, {29'd0, b_busy, b_req, b_ack}, 32'd0);
    endtask

    initial begin
        int base, peak, npulse, cyc, i;
        repeat (3) @(negedge clk);
        chk("rst_a_outputs", {27'd0, a_req, a_busy, a_done, a_ovf, 1'b0} | 32'(a_pend), 32'd0);
        chk("rst_b_outputs", {27'd0, b_req, b_busy, b_done, b_ovf, 1'b0} | 32'(b_pend), 32'd0);
        a_cmp_en = 1'b1;
        rst = 1'b0;

        // Single event, ack latency 3
        a_lat_cfg = 3; a_ack_en = 1'b1; base = a_done_cnt;
        @(negedge clk); a_pulse = 1'b1;
        @(negedge clk); a_pulse = 1'b0;
        chk("t1_pending_after_pulse", 32'(a_pend), 32'd1);
        chk("t1_req_not_yet", 32'(a_req), 32'd0);
        chk("t1_busy_with_pulse", 32'(a_busy), 32'd1);
        @(negedge clk);
        chk("t1_req_two_cycles", 32'(a_req), 32'd1);
        chk("t1_pending_launched", 32'(a_pend), 32'd0);
        a_drain("t1", 200, peak);
        chk("t1_done_count", 32'(a_done_cnt - base), 32'd1);

        // Five back-to-back events, slow ack
        a_lat_cfg = 10; base = a_done_cnt;
        a_pulses(5);
        a_drain("t2", 600, peak);
        chk("t2_pending_peak", 32'(peak), 32'd4);
        chk("t2_done_count", 32'(a_done_cnt - base), 32'd5);

        // Reset while in REQ with two pending
        a_ack_en = 1'b0; base = a_done_cnt;
        a_pulses(3);
        chk("t5_in_req", 32'(a_req), 32'd1);
        chk("t5_two_pending", 32'(a_pend), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_clear", {29'd0, a_req, a_busy, 1'b0} | 32'(a_pend), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_done_after_abort", 32'(a_done_cnt - base), 32'd0);
        a_lat_cfg = 2; a_ack_en = 1'b1;
        a_pulses(1);
        a_drain("t5_clean", 200, peak);
        chk("t5_clean_done", 32'(a_done_cnt - base), 32'd1);

        // Random traffic on A with random ack latency, model checked every cycle
        a_rand = 1'b1; base = a_done_cnt;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk); a_pulse = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk); a_pulse = 1'b0;
        a_drain("a_rand", 3000, peak);

        // B: saturation with ack held low
        b_ack_en = 1'b0; base = b_ovf_cnt;
        repeat (6) begin
            @(negedge clk); b_pulse = 1'b1;
        end
        @(negedge clk); b_pulse = 1'b0;
        @(negedge clk);
        chk("t3_pending_saturated", 32'(b_pend), 32'd3);
        chk("t3_overflow_count", 32'(b_ovf_cnt - base), 32'd2);
        chk("t3_req_held", 32'(b_req), 32'd1);

        // Pulse in the launch cycle at count==max
        b_ack_en = 1'b1; b_async = 1'b0; cyc = b_done_cnt;
        i = 0;
        do begin
            @(negedge clk); i++;
        end while (!b_done && i < 200);
        chk("t4_first_done_seen", 32'(b_done), 32'd1);
        b_pulse = 1'b1;
        @(negedge clk); b_pulse = 1'b0;
        chk("t4_pending_stays_max", 32'(b_pend), 32'd3);
        chk("t4_no_overflow", 32'(b_ovf), 32'd0);
        chk("t4_relaunched", 32'(b_req), 32'd1);
        b_drain("t4", 400);
        chk("t4_done_count", 32'(b_done_cnt - cyc), 32'd5);
        chk("t4_overflow_total", 32'(b_ovf_cnt - base), 32'd2);

        // B: 1000 random events with ack at random phase
        b_async = 1'b1; base = b_ovf_cnt; cyc = b_done_cnt;
        npulse = 0; i = 0;
        while (npulse < 1000 && i < 20000) begin
            @(negedge clk);
            b_pulse = ($urandom_range(0, 3) == 0);
            if (b_pulse) npulse++;
            i++;
        end
        @(negedge clk); b_pulse = 1'b0;
        b_drain("t6", 4000);
        chk("t6_pulses_sent", 32'(npulse), 32'd1000);
        chk("t6_events_conserved", 32'(b_done_cnt - cyc), 32'(npulse - (b_ovf_cnt - base)));
        chk("t6_pending_empty", 32'(b_pend), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #(P * 80000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
